// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM state encoding and the default frame start byte.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } ldr_state_t;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs payload bytes LSB-first into 32-bit words and keeps the running XOR checksum.
// Latency: word_vld/word_dat one cycle after the 4th byte; no backpressure (caller gates byte_vld).
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [1:0]  byte_idx,
    output logic        word_vld,
    output logic [31:0] word_dat,
    output logic [7:0]  csum
);

    logic [23:0] lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= 2'd0;
            word_vld <= 1'b0;
            word_dat <= 32'd0;
            csum     <= 8'd0;
            lanes    <= 24'd0;
        end else begin
            word_vld <= byte_vld && (byte_idx == 2'd3);
            if (clr) begin
                byte_idx <= 2'd0;
                csum     <= 8'd0;
            end else if (byte_vld) begin
                csum     <= csum ^ byte_dat;
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    lanes[7:0]   <= byte_dat;
                    2'd1:    lanes[15:8]  <= byte_dat;
                    2'd2:    lanes[23:16] <= byte_dat;
                    default: word_dat     <= {byte_dat, lanes};
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC/CNT/payload/CSUM frames into instruction_mem writes, holds core in reset until verified.
// Latency: write strobe one cycle after a word's 4th byte; rx_ready drops only once the image is done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         N           = 32,
    parameter int         DEPTH_WORDS = 1024,
    parameter int         TIMEOUT     = 100000,
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         rx_ready,
    output logic         imem_we,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] imem_wdata,
    output logic         core_rst,
    output logic         done,
    output logic         error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ldr_state_t    state, nxt;
    logic [7:0]    cnt_lo;
    logic [15:0]   cnt;
    logic [15:0]   word_idx;
    logic [TW-1:0] idle_cnt;
    logic [15:0]   len_full;
    logic          hs, active, is_magic, last_byte, timed_out;
    logic          asm_vld, asm_clr;
    logic [1:0]    byte_idx;
    logic [31:0]   asm_word;
    logic [7:0]    csum;

    assign hs        = rx_valid & rx_ready;
    assign is_magic  = (rx_data == MAGIC);
    assign active    = state inside {LEN0, LEN1, DATA, CSUM};
    assign len_full  = {rx_data, cnt_lo};
    assign asm_vld   = hs && (state == DATA);
    // A fresh frame (from IDLE or a recovery from ERR) restarts lane and checksum tracking.
    assign asm_clr   = hs && is_magic && (state == IDLE || state == ERR);
    assign last_byte = asm_vld && (byte_idx == 2'd3);
    assign timed_out = active && !hs && (idle_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (hs && is_magic) nxt = LEN0;
            LEN0: if (hs) nxt = LEN1;
            LEN1: if (hs) begin
                if (17'(len_full) > 17'(DEPTH_WORDS)) nxt = ERR;
                else if (len_full == 16'd0)          nxt = CSUM;
                else                                 nxt = DATA;
            end
            DATA: if (last_byte && (word_idx + 16'd1 == cnt)) nxt = CSUM;
            CSUM: if (hs) nxt = (rx_data == csum) ? DONE : ERR;
            DONE: nxt = DONE;
            ERR:  if (hs && is_magic) nxt = LEN0;
            default: nxt = IDLE;
        endcase
        if (timed_out) nxt = ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cnt_lo    <= 8'd0;
            cnt       <= 16'd0;
            word_idx  <= 16'd0;
            idle_cnt  <= '0;
            imem_addr <= '0;
        end else begin
            state    <= nxt;
            rx_ready <= (nxt != DONE);
            core_rst <= (nxt != DONE);
            done     <= (nxt == DONE);
            error    <= (nxt == ERR);
            if (hs && state == LEN0) cnt_lo <= rx_data;
            if (hs && state == LEN1) begin
                cnt      <= len_full;
                word_idx <= 16'd0;
            end
            if (last_byte) begin
                imem_addr <= N'(word_idx) << 2;
                word_idx  <= word_idx + 16'd1;
            end
            if (active && !hs && nxt != ERR) idle_cnt <= idle_cnt + 1'b1;
            else                             idle_cnt <= '0;
        end
    end

    word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (asm_clr),
        .byte_vld (asm_vld),
        .byte_dat (rx_data),
        .byte_idx (byte_idx),
        .word_vld (imem_we),
        .word_dat (asm_word),
        .csum     (csum)
    );

    assign imem_wdata = N'(asm_word);

endmodule
